// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, sync pulses, active-area flag and line/frame strobes.
// Optional frame counter enabled by defining VGA_TIMING_FRAMECNT_EN.
module vga_timing_gen #(
   parameter int       H_ACTIVE = 800,
   parameter int       H_FP     = 40,
   parameter int       H_SYNC   = 128,
   parameter int       H_BP     = 88,
   parameter int       V_ACTIVE = 600,
   parameter int       V_FP     = 1,
   parameter int       V_SYNC   = 4,
   parameter int       V_BP     = 23,
   parameter bit       HS_POL   = 1'b1,
   parameter bit       VS_POL   = 1'b1,
   parameter int       CNT_W    = 11
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             pixEn,
   output logic [CNT_W-1:0] hPos,
   output logic [CNT_W-1:0] vPos,
   output logic             HSYNC,
   output logic             VSYNC,
   output logic             videoOn,
   output logic             lineStart,
   output logic             frameStart
`ifdef VGA_TIMING_FRAMECNT_EN
   ,
   output logic [15:0]      frameCnt
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic             h_wrap;
   logic [CNT_W-1:0] h_nxt;
   logic [CNT_W-1:0] v_nxt;
   logic             hs_act;
   logic             vs_act;
   logic             von_nxt;
   logic             frame_nxt;

   // Decode from next-state counters so the registered flags line up with hPos/vPos.
   always_comb begin
      h_wrap    = (hPos == H_LAST);
      h_nxt     = h_wrap ? '0 : hPos + 1'b1;
      v_nxt     = vPos;
      if (h_wrap) begin
         v_nxt = (vPos == V_LAST) ? '0 : vPos + 1'b1;
      end
      hs_act    = (h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST);
      vs_act    = (v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST);
      von_nxt   = (h_nxt < H_ACT) && (v_nxt < V_ACT);
      frame_nxt = h_wrap && (v_nxt == '0);
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         hPos       <= H_LAST;
         vPos       <= V_LAST;
         HSYNC      <= ~HS_POL;
         VSYNC      <= ~VS_POL;
         videoOn    <= 1'b0;
         lineStart  <= 1'b0;
         frameStart <= 1'b0;
      end else if (pixEn) begin
         hPos       <= h_nxt;
         vPos       <= v_nxt;
         HSYNC      <= hs_act ? HS_POL : ~HS_POL;
         VSYNC      <= vs_act ? VS_POL : ~VS_POL;
         videoOn    <= von_nxt;
         lineStart  <= h_wrap;
         frameStart <= frame_nxt;
      end else begin
         // Strobes are one CLK wide whatever the enable duty cycle.
         lineStart  <= 1'b0;
         frameStart <= 1'b0;
      end
   end

`ifdef VGA_TIMING_FRAMECNT_EN
   always_ff @(posedge CLK) begin
      if (rst) begin
         frameCnt <= '0;
      end else if (pixEn && frame_nxt) begin
         frameCnt <= frameCnt + 16'd1;
      end
   end
`endif

endmodule
